// File: rtl/i2c_slave_if.sv
// I2C target bus/user-side signal bundle.
// slave  : the i2c_slave responder (pins in, open-drain enable and user strobes out)
// master : whatever drives the pins and serves the byte handshake
interface i2c_slave_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       start_det;
    logic       stop_det;

    modport slave (
        input  scl_i, sda_i, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, start_det, stop_det
    );

    modport master (
        output scl_i, sda_i, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, start_det, stop_det
    );
endinterface

// File: rtl/i2c_slave.sv
// I2C target responder with a fixed 7-bit address.
// SCL/SDA are synchronised (2 FF) plus one history FF; all bus events come
// from the synchronised copies. Bits are sampled on SCL rise, SDA is only
// changed on SCL fall, and SDA is driven open-drain through sda_oe.
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input logic        clk,
    input logic        rst,
    i2c_slave_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] byte_in;

    state_t     state_q, state_n;
    logic [3:0] cnt_q, cnt_n;       // bits clocked in the current slot
    logic [6:0] sh_q, sh_n;         // shift register (MSB leaves/arrives first)
    logic       rw_q, rw_n;
    logic       oe_q, oe_n;
    logic [7:0] rx_data_q, rx_data_n;
    logic       rx_valid_q, rx_valid_n;
    logic       tx_req_q, tx_req_n;
    logic       busy_q, busy_n;
    logic       start_q, start_n;
    logic       stop_q, stop_n;

    // Pin synchronisers and edge-history flops; idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    // START/STOP need SCL high on both the current and previous sample.
    assign start_c  = scl_s & scl_d & ~sda_s & sda_d;
    assign stop_c   = scl_s & scl_d & sda_s & ~sda_d;
    assign byte_in  = {sh_q, sda_s};

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            sh_q       <= 7'd0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            sh_q       <= sh_n;
            rw_q       <= rw_n;
            oe_q       <= oe_n;
            rx_data_q  <= rx_data_n;
            rx_valid_q <= rx_valid_n;
            tx_req_q   <= tx_req_n;
            busy_q     <= busy_n;
            start_q    <= start_n;
            stop_q     <= stop_n;
        end
    end

    // Next-state logic: START/STOP override everything, otherwise the
    // current slot advances on synchronised SCL edges.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        sh_n       = sh_q;
        rw_n       = rw_q;
        oe_n       = oe_q;
        rx_data_n  = rx_data_q;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = busy_q;
        start_n    = 1'b0;
        stop_n     = 1'b0;

        if (start_c) begin
            state_n = S_ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            start_n = 1'b1;
        end else if (stop_c) begin
            state_n = S_IDLE;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            stop_n  = 1'b1;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    sh_n  = byte_in[6:0];
                    cnt_n = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_n = 4'd0;
                        // Address 0 (general call) is never claimed.
                        if (byte_in[7:1] == ADDR && byte_in[7:1] != 7'd0) begin
                            state_n = S_ADDR_ACK;
                            busy_n  = 1'b1;
                            rw_n    = byte_in[0];
                        end else begin
                            state_n = S_WAIT;
                        end
                    end
                end
                // ACK slots we drive: pull low on the fall ending bit 8,
                // release (or load the first read bit) on the fall ending bit 9.
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_rise) begin
                        cnt_n = 4'd1;
                        if (state_q == S_ADDR_ACK && rw_q) tx_req_n = 1'b1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            oe_n = 1'b1;
                        end else begin
                            cnt_n = 4'd0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_n = S_RD;
                                sh_n    = bus.tx_data[6:0];
                                oe_n    = ~bus.tx_data[7];
                            end else begin
                                state_n = S_WR;
                                oe_n    = 1'b0;
                            end
                        end
                    end
                end
                S_WR: if (scl_rise) begin
                    sh_n  = byte_in[6:0];
                    cnt_n = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rx_data_n  = byte_in;
                        rx_valid_n = 1'b1;
                        state_n    = S_WR_ACK;
                        cnt_n      = 4'd0;
                    end
                end
                // Bit 7 is already on the line; each fall presents the next.
                S_RD: begin
                    if (scl_rise) begin
                        cnt_n = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_n    = 1'b0;
                            state_n = S_RD_ACK;
                            cnt_n   = 4'd0;
                        end else begin
                            oe_n = ~sh_q[6];
                            sh_n = {sh_q[5:0], 1'b0};
                        end
                    end
                end
                // Master's ACK keeps the read going; NACK ends our turn.
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            tx_req_n = 1'b1;
                            cnt_n    = 4'd1;
                        end else begin
                            state_n = S_WAIT;
                            oe_n    = 1'b0;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        state_n = S_RD;
                        cnt_n   = 4'd0;
                        sh_n    = bus.tx_data[6:0];
                        oe_n    = ~bus.tx_data[7];
                    end
                end
                S_IDLE, S_WAIT: ;
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign bus.sda_oe    = oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_req    = tx_req_q;
    assign bus.busy      = busy_q;
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed + randomized bench for i2c_slave: a bit-level I2C master model
// drives the pins, a byte-level reference (expected bytes, expected pulse
// counts, expected ACK levels) judges the responses.
module tb_i2c_slave;

    localparam int Q = 80;  // quarter SCL period (8 clk of 10)

    logic clk = 1'b0;
    logic rst;
    logic scl_m, sda_m;
    logic [7:0] tx_d;

    i2c_slave_if bus ();

    assign bus.scl_i   = scl_m;
    assign bus.sda_i   = sda_m & ~bus.sda_oe;  // wired-AND open drain
    assign bus.tx_data = tx_d;

    i2c_slave dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int fails = 0;

    int rxv_cnt = 0, txr_cnt = 0, st_cnt = 0, sp_cnt = 0;
    int oe_cyc = 0, busy_cyc = 0;
    logic [7:0] rx_log[$];

    // Pulse/level monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rxv_cnt++;
            rx_log.push_back(bus.rx_data);
        end
        if (bus.tx_req) txr_cnt++;
        if (bus.start_det) st_cnt++;
        if (bus.stop_det) sp_cnt++;
        if (bus.sda_oe) oe_cyc++;
        if (bus.busy) busy_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    // One SCL clock; optionally present the next tx byte mid-high (after tx_req).
    task automatic clk_bit(input logic drv, output logic smp, input logic upd, input logic [7:0] ntx);
        sda_m = drv; #(Q);
        scl_m = 1'b1; #(Q);
        smp = bus.sda_i;
        if (upd) tx_d = ntx;
        #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic [7:0] ntx, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s, 1'b0, 8'h00);
        clk_bit(1'b1, ack, 1'b1, ntx);
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] ntx, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s, 1'b0, 8'h00);
            b[i] = s;
        end
        clk_bit(mack, s, 1'b1, ntx);
    endtask

    // Read two bytes: master ACKs the first, NACKs the second.
    task automatic do_read(input logic [7:0] t0, input logic [7:0] t1);
        logic ack;
        logic [7:0] b0, b1;
        int txr0;
        txr0 = txr_cnt;
        i2c_start();
        write_byte(8'h85, t0, ack);
        chk("rd_addr_ack", ack, 1'b0);
        read_byte(1'b0, t1, b0);
        read_byte(1'b1, 8'h00, b1);
        chk("rd_byte0", b0, t0);
        chk("rd_byte1", b1, t1);
        chk("rd_sda_released", bus.sda_oe, 1'b0);
        chk("rd_tx_req_cnt", txr_cnt - txr0, 2);
        i2c_stop();
        chk("rd_busy_after_stop", bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic ack, s;
        logic [7:0] d, b;
        logic [6:0] a;
        logic [7:0] exp_q[$];
        int rxv0, st0, sp0, oe0, busy0;

        rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tx_d = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sda_oe", bus.sda_oe, 1'b0);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 1'b0);
        chk("rst_tx_req", bus.tx_req, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_start_det", bus.start_det, 1'b0);
        chk("rst_stop_det", bus.stop_det, 1'b0);
        @(negedge clk) rst = 1'b1;
        repeat (4) @(posedge clk);

        // Directed write 0x84, 0xA5.
        rxv0 = rxv_cnt; st0 = st_cnt; sp0 = sp_cnt;
        i2c_start();
        write_byte(8'h84, 8'h00, ack);
        chk("wr_addr_ack", ack, 1'b0);
        chk("wr_busy", bus.busy, 1'b1);
        write_byte(8'hA5, 8'h00, ack);
        chk("wr_data_ack", ack, 1'b0);
        i2c_stop();
        chk("wr_rx_valid_cnt", rxv_cnt - rxv0, 1);
        chk("wr_rx_data", bus.rx_data, 8'hA5);
        chk("wr_start_cnt", st_cnt - st0, 1);
        chk("wr_stop_cnt", sp_cnt - sp0, 1);
        chk("wr_busy_after_stop", bus.busy, 1'b0);

        // Randomized multi-byte write against expected byte queue.
        rx_log.delete();
        exp_q.delete();
        i2c_start();
        write_byte(8'h84, 8'h00, ack);
        chk("rwr_addr_ack", ack, 1'b0);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            write_byte(d, 8'h00, ack);
            chk("rwr_data_ack", ack, 1'b0);
        end
        i2c_stop();
        chk("rwr_count", rx_log.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_log.size() > 0)
            chk("rwr_byte", rx_log.pop_front(), exp_q.pop_front());

        // Reads: directed then random.
        do_read(8'h3C, 8'hC3);
        do_read(8'($urandom), 8'($urandom));

        // Address mismatches, including general call.
        for (int k = 0; k < 3; k++) begin
            if (k == 0) a = 7'h48;
            else if (k == 1) a = 7'h00;
            else begin
                a = 7'($urandom);
                if (a == 7'h42) a = 7'h43;
            end
            rxv0 = rxv_cnt; oe0 = oe_cyc; busy0 = busy_cyc;
            i2c_start();
            write_byte({a, 1'b0}, 8'h00, ack);
            chk("mm_addr_nack", ack, 1'b1);
            write_byte(8'h11, 8'h00, ack);
            chk("mm_data_nack", ack, 1'b1);
            i2c_stop();
            chk("mm_oe_never", oe_cyc - oe0, 0);
            chk("mm_no_rx_valid", rxv_cnt - rxv0, 0);
            chk("mm_busy_never", busy_cyc - busy0, 0);
        end

        // Repeated START: write 0x07, Sr, read 0x5A with NACK.
        rxv0 = rxv_cnt; st0 = st_cnt;
        i2c_start();
        write_byte(8'h84, 8'h00, ack);
        chk("sr_wr_addr_ack", ack, 1'b0);
        write_byte(8'h07, 8'h00, ack);
        chk("sr_wr_data_ack", ack, 1'b0);
        i2c_start();
        write_byte(8'h85, 8'h5A, ack);
        chk("sr_rd_addr_ack", ack, 1'b0);
        read_byte(1'b1, 8'h00, b);
        chk("sr_rd_byte", b, 8'h5A);
        i2c_stop();
        chk("sr_rx_data", bus.rx_data, 8'h07);
        chk("sr_rx_valid_cnt", rxv_cnt - rxv0, 1);
        chk("sr_start_cnt", st_cnt - st0, 2);

        // STOP after 3 data bits, then bits without START are ignored.
        rxv0 = rxv_cnt; sp0 = sp_cnt;
        i2c_start();
        write_byte(8'h84, 8'h00, ack);
        chk("sm_addr_ack", ack, 1'b0);
        for (int k = 0; k < 3; k++) clk_bit(1'($urandom), s, 1'b0, 8'h00);
        i2c_stop();
        chk("sm_no_rx_valid", rxv_cnt - rxv0, 0);
        chk("sm_sda_oe", bus.sda_oe, 1'b0);
        chk("sm_busy", bus.busy, 1'b0);
        chk("sm_stop_cnt", sp_cnt - sp0, 1);
        scl_m = 1'b0; #(Q);
        write_byte(8'h84, 8'h00, ack);
        chk("sm_idle_ignores", ack, 1'b1);
        i2c_stop();

        // Reset during the 4th bit of a read of 0x00 (slave pulling low).
        i2c_start();
        write_byte(8'h85, 8'h00, ack);
        chk("rr_addr_ack", ack, 1'b0);
        for (int k = 0; k < 3; k++) clk_bit(1'b1, s, 1'b0, 8'h00);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        chk("rr_oe_before", bus.sda_oe, 1'b1);
        rst = 1'b0;
        #1;
        chk("rr_oe_async", bus.sda_oe, 1'b0);
        chk("rr_busy_async", bus.busy, 1'b0);
        #(Q);
        scl_m = 1'b0; #(Q);
        rst = 1'b1; #(Q);
        oe0 = oe_cyc; rxv0 = rxv_cnt;
        write_byte(8'h84, 8'h00, ack);
        chk("rr_ignored_ack", ack, 1'b1);
        write_byte(8'h33, 8'h00, ack);
        chk("rr_ignored_oe", oe_cyc - oe0, 0);
        chk("rr_ignored_rx", rxv_cnt - rxv0, 0);
        d = 8'($urandom);
        i2c_start();
        write_byte(8'h84, 8'h00, ack);
        chk("rr_fresh_ack", ack, 1'b0);
        write_byte(d, 8'h00, ack);
        i2c_stop();
        chk("rr_fresh_rx", bus.rx_data, d);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
